// File: rtl/usbh_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usbh_phy_pkg
// Brief    : Shared types and line constants for the USB host UTMI TX PHY.
// Revision : 1.0
// ============================================================================
package usbh_phy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_t;

  // Line values packed as {dp, dn}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned STUFF_LIMIT = 6;

  localparam logic [1:0] OPMODE_NORMAL = 2'b00;
  localparam logic [1:0] OPMODE_RAW    = 2'b10;

  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usbh_utmi_tx_phy_if.sv
`default_nettype none
// ============================================================================
// Module   : usbh_utmi_tx_phy_if
// Brief    : UTMI transmit handshake and USB line drive bundle.
// Revision : 1.0
// ============================================================================
interface usbh_utmi_tx_phy_if;

  logic [7:0] utmi_data_out_i;
  logic       utmi_txvalid_i;
  logic [1:0] utmi_op_mode_i;
  logic       utmi_txready_o;
  logic       usb_dp_o;
  logic       usb_dn_o;
  logic       usb_tx_oen_o;

  modport master (
    output utmi_data_out_i, utmi_txvalid_i, utmi_op_mode_i,
    input  utmi_txready_o, usb_dp_o, usb_dn_o, usb_tx_oen_o
  );

  modport slave (
    input  utmi_data_out_i, utmi_txvalid_i, utmi_op_mode_i,
    output utmi_txready_o, usb_dp_o, usb_dn_o, usb_tx_oen_o
  );

endinterface
`default_nettype wire

// File: rtl/usbh_tx_bitstuff_nrzi.sv
`default_nettype none
// ============================================================================
// Module   : usbh_tx_bitstuff_nrzi
// Brief    : Consecutive-ones counter, stuff request and NRZI line register.
// Revision : 1.0
// ============================================================================
module usbh_tx_bitstuff_nrzi
  import usbh_phy_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_clear,
  input  wire logic       i_launch,
  input  wire logic       i_bit,
  output logic            o_stuff_req,
  output logic [1:0]      o_line
);

  logic [2:0] r_ones;
  logic [1:0] r_line;

  // A launch while a stuff is pending sends the stuffed 0 regardless of i_bit
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ones <= 3'd0;
      r_line <= LINE_J;
    end else if (i_launch) begin
      if (o_stuff_req || !i_bit) begin
        r_ones <= 3'd0;
        r_line <= nrzi_toggle(r_line);
      end else begin
        r_ones <= r_ones + 3'd1;
      end
    end
  end

  assign o_stuff_req = (r_ones == 3'(STUFF_LIMIT));
  assign o_line      = r_line;

endmodule
`default_nettype wire

// File: rtl/usbh_utmi_tx_phy.sv
`default_nettype none
// ============================================================================
// Module   : usbh_utmi_tx_phy
// Brief    : Full-speed USB host transmit PHY behind a UTMI-style byte port.
// Revision : 1.0
// ============================================================================
module usbh_utmi_tx_phy
  import usbh_phy_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  usbh_utmi_tx_phy_if.slave  bus
);

  localparam int unsigned c_timer_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t            r_state, w_state_nxt;
  logic [c_timer_w-1:0] r_timer, w_timer_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic [2:0]           r_idx,   w_idx_nxt;
  logic                 r_raw,   w_raw_nxt;

  logic       w_bit_end;
  logic       w_launch;
  logic       w_launch_bit;
  logic       w_clear;
  logic       w_txready;
  logic       w_stuff_req;
  logic       w_stuff_next;
  logic [1:0] w_nrzi_line;
  logic [1:0] w_line;

  usbh_tx_bitstuff_nrzi u_stuff (
    .clk         (clk_i),
    .rst         (rst_i),
    .i_clear     (w_clear),
    .i_launch    (w_launch),
    .i_bit       (w_launch_bit),
    .o_stuff_req (w_stuff_req),
    .o_line      (w_nrzi_line)
  );

  assign w_bit_end    = (r_timer == c_timer_w'(CLKS_PER_BIT - 1));
  assign w_stuff_next = w_stuff_req && !r_raw;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_raw   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_raw   <= w_raw_nxt;
    end
  end

  // r_shift[0] is the data bit currently on the line; r_idx counts data bits
  // of the current byte and stays put across a stuffed bit.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = w_bit_end ? '0 : r_timer + c_timer_w'(1);
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_idx;
    w_raw_nxt    = r_raw;
    w_launch     = 1'b0;
    w_launch_bit = 1'b0;
    w_clear      = 1'b0;
    w_txready    = 1'b0;

    case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        w_idx_nxt   = '0;
        w_clear     = 1'b1;
        if (bus.utmi_txvalid_i && bus.utmi_op_mode_i == OPMODE_NORMAL) begin
          w_state_nxt  = SYNC;
          w_raw_nxt    = 1'b0;
          w_shift_nxt  = SYNC_BYTE;
          w_launch     = 1'b1;
          w_launch_bit = SYNC_BYTE[0];
          w_clear      = 1'b0;
        end else if (bus.utmi_txvalid_i && bus.utmi_op_mode_i == OPMODE_RAW) begin
          // Raw packets have no SYNC, so the byte presented at start is sent first
          w_state_nxt = DATA;
          w_raw_nxt   = 1'b1;
          w_shift_nxt = bus.utmi_data_out_i;
        end
      end

      SYNC, DATA: begin
        w_clear = r_raw;
        if (w_bit_end) begin
          if (w_stuff_next) begin
            w_launch = 1'b1;
          end else if (r_idx != 3'd7) begin
            w_idx_nxt    = r_idx + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_launch     = !r_raw;
            w_launch_bit = r_shift[1];
          end else begin
            w_txready = 1'b1;
            w_idx_nxt = '0;
            if (bus.utmi_txvalid_i) begin
              w_state_nxt  = DATA;
              w_shift_nxt  = bus.utmi_data_out_i;
              w_launch     = !r_raw;
              w_launch_bit = bus.utmi_data_out_i[0];
            end else if (r_raw) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = EOP_SE0;
            end
          end
        end
      end

      EOP_SE0: begin
        w_clear = 1'b1;
        if (w_bit_end) begin
          if (r_idx == 3'd1) begin
            w_idx_nxt   = '0;
            w_state_nxt = EOP_J;
          end else begin
            w_idx_nxt = 3'd1;
          end
        end
      end

      EOP_J: begin
        w_clear = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_line = LINE_J;
    case (r_state)
      SYNC, DATA: w_line = r_raw ? {r_shift[0], ~r_shift[0]} : w_nrzi_line;
      EOP_SE0:    w_line = LINE_SE0;
      default:    w_line = LINE_J;
    endcase
  end

  assign bus.usb_dp_o       = w_line[1];
  assign bus.usb_dn_o       = w_line[0];
  assign bus.usb_tx_oen_o   = (r_state == IDLE);
  assign bus.utmi_txready_o = w_txready;

endmodule
`default_nettype wire

// File: tb/tb_usbh_utmi_tx_phy.sv
`default_nettype none
// ============================================================================
// Module   : tb_usbh_utmi_tx_phy
// Brief    : Self-checking bench for usbh_utmi_tx_phy using a bit-stream model.
// Revision : 1.0
// ============================================================================
module tb_usbh_utmi_tx_phy;

  localparam int CLKS = 4;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usbh_utmi_tx_phy_if bus ();

  usbh_utmi_tx_phy #(.CLKS_PER_BIT(CLKS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pkt_q[$];
  logic [1:0] exp_line[$];
  logic       exp_oen[$];
  logic       exp_rdy[$];
  int         pkt_len;
  int         rdy_seen;
  bit         glitch_en = 1'b0;

  // Expected per-cycle line, enable and txready from the packet's bit stream
  task automatic build_expected(input logic [1:0] mode, input int idle_after);
    bit         bits[$];
    bit         mk[$];
    int         ones;
    logic [1:0] lvl;
    logic [7:0] v;
    exp_line.delete(); exp_oen.delete(); exp_rdy.delete();
    if (mode == 2'b10) begin
      foreach (pkt_q[s])
        for (int i = 0; i < 8; i++) begin
          bits.push_back(pkt_q[s][i]);
          mk.push_back(i == 7);
        end
      foreach (bits[j])
        for (int c = 0; c < CLKS; c++) begin
          exp_line.push_back(bits[j] ? J : K);
          exp_oen.push_back(1'b0);
          exp_rdy.push_back(mk[j] && c == CLKS - 1);
        end
    end else begin
      ones = 0;
      for (int s = 0; s <= pkt_q.size(); s++) begin
        v = (s == 0) ? 8'h80 : pkt_q[s-1];
        for (int i = 0; i < 8; i++) begin
          bits.push_back(v[i]);
          mk.push_back(1'b0);
          ones = v[i] ? ones + 1 : 0;
          if (ones == 6) begin
            bits.push_back(1'b0);
            mk.push_back(1'b0);
            ones = 0;
          end
        end
        mk[mk.size()-1] = 1'b1;
      end
      lvl = J;
      foreach (bits[j]) begin
        if (!bits[j]) lvl = (lvl == J) ? K : J;
        for (int c = 0; c < CLKS; c++) begin
          exp_line.push_back(lvl);
          exp_oen.push_back(1'b0);
          exp_rdy.push_back(mk[j] && c == CLKS - 1);
        end
      end
      for (int c = 0; c < 3 * CLKS; c++) begin
        exp_line.push_back(c < 2 * CLKS ? SE0 : J);
        exp_oen.push_back(1'b0);
        exp_rdy.push_back(1'b0);
      end
    end
    pkt_len = exp_line.size();
    for (int c = 0; c < idle_after; c++) begin
      exp_line.push_back(J);
      exp_oen.push_back(1'b1);
      exp_rdy.push_back(1'b0);
    end
  endtask

  // Sends pkt_q as a controller would and checks every cycle against the model
  task automatic run_packet(input string name, input logic [1:0] mode, input bit start_now,
                            input int idle_after, input bit chain,
                            input logic [1:0] chain_mode, input logic [7:0] chain_byte);
    int   di;
    logic rdy, tv;
    bit   glitch;
    build_expected(mode, idle_after);
    if (!start_now) begin
      bus.utmi_op_mode_i  = mode;
      bus.utmi_data_out_i = pkt_q[0];
      bus.utmi_txvalid_i  = 1'b1;
      @(posedge clk); #1;
    end
    di = 0;
    if (mode == 2'b10) begin
      di = 1;
      if (di < pkt_q.size()) bus.utmi_data_out_i = pkt_q[di];
      else begin bus.utmi_txvalid_i = 1'b0; bus.utmi_data_out_i = 8'($urandom); end
    end
    bus.utmi_op_mode_i = 2'($urandom);
    glitch   = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < exp_line.size(); k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.usb_dp_o, bus.usb_dn_o} !== exp_line[k] || bus.usb_tx_oen_o !== exp_oen[k] ||
          bus.utmi_txready_o !== exp_rdy[k]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got dp/dn=%b%b oen=%b txready=%b, expected dp/dn=%b oen=%b txready=%b",
                 name, k, bus.usb_dp_o, bus.usb_dn_o, bus.usb_tx_oen_o, bus.utmi_txready_o,
                 exp_line[k], exp_oen[k], exp_rdy[k]);
      end
      rdy = bus.utmi_txready_o;
      tv  = bus.utmi_txvalid_i;
      if (rdy === 1'b1) rdy_seen++;
      @(posedge clk); #1;
      if (glitch) begin bus.utmi_txvalid_i = 1'b1; glitch = 1'b0; end
      if (rdy === 1'b1 && tv) begin
        di++;
        if (di < pkt_q.size()) bus.utmi_data_out_i = pkt_q[di];
        else begin bus.utmi_txvalid_i = 1'b0; bus.utmi_data_out_i = 8'($urandom); end
      end else if (glitch_en && bus.utmi_txvalid_i && k + 1 < pkt_len && !exp_rdy[k+1] &&
                   $urandom_range(7) == 0) begin
        bus.utmi_txvalid_i = 1'b0;
        glitch = 1'b1;
      end
      if (chain && k == pkt_len - 2) begin
        bus.utmi_op_mode_i  = chain_mode;
        bus.utmi_data_out_i = chain_byte;
        bus.utmi_txvalid_i  = 1'b1;
      end
    end
  endtask

  task automatic check_rdy_count(input string name, input int want);
    n_checks++;
    if (rdy_seen != want) begin
      n_fail++;
      $display("FAIL %s txready pulses: got %0d, expected %0d", name, rdy_seen, want);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.usb_dp_o, bus.usb_dn_o} !== J || bus.usb_tx_oen_o !== 1'b1 ||
          bus.utmi_txready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got dp/dn=%b%b oen=%b txready=%b, expected dp/dn=10 oen=1 txready=0",
                 name, k, bus.usb_dp_o, bus.usb_dn_o, bus.usb_tx_oen_o, bus.utmi_txready_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.utmi_txvalid_i  = 1'b0;
    bus.utmi_data_out_i = 8'h00;
    bus.utmi_op_mode_i  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset", 4);
  endtask

  task automatic test_single_byte();
    pkt_q = '{8'hA5};
    run_packet("single_a5", 2'b00, 1'b0, 3, 1'b0, 2'b00, 8'h00);
    check_rdy_count("single_a5", 2);
  endtask

  task automatic test_stuff_ff();
    pkt_q = '{8'hFF};
    run_packet("stuff_ff", 2'b00, 1'b0, 3, 1'b0, 2'b00, 8'h00);
    check_rdy_count("stuff_ff", 2);
  endtask

  task automatic test_back_to_back();
    pkt_q = '{8'h3F, 8'h00};
    run_packet("b2b_3f_00", 2'b00, 1'b0, 3, 1'b0, 2'b00, 8'h00);
    check_rdy_count("b2b_3f_00", 3);
  endtask

  task automatic test_packet_chain();
    pkt_q = '{8'h5A};
    run_packet("chain_first", 2'b00, 1'b0, 1, 1'b1, 2'b00, 8'hC3);
    pkt_q = '{8'hC3};
    run_packet("chain_second", 2'b00, 1'b1, 3, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_reset_mid_packet();
    pkt_q = '{8'($urandom), 8'($urandom)};
    build_expected(2'b00, 0);
    bus.utmi_op_mode_i  = 2'b00;
    bus.utmi_data_out_i = pkt_q[0];
    bus.utmi_txvalid_i  = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.usb_dp_o, bus.usb_dn_o} !== exp_line[k] || bus.usb_tx_oen_o !== exp_oen[k] ||
          bus.utmi_txready_o !== exp_rdy[k]) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: got dp/dn=%b%b oen=%b txready=%b, expected dp/dn=%b oen=%b txready=%b",
                 k, bus.usb_dp_o, bus.usb_dn_o, bus.usb_tx_oen_o, bus.utmi_txready_o,
                 exp_line[k], exp_oen[k], exp_rdy[k]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.utmi_txvalid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("after_reset", 16);
    pkt_q = '{8'($urandom)};
    run_packet("post_reset", 2'b00, 1'b0, 3, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_nondriving();
    bus.utmi_data_out_i = 8'($urandom);
    bus.utmi_op_mode_i  = 2'b01;
    bus.utmi_txvalid_i  = 1'b1;
    check_idle("opmode_01", 100);
    bus.utmi_op_mode_i  = 2'b11;
    check_idle("opmode_11", 100);
    bus.utmi_txvalid_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_raw_single();
    pkt_q = '{8'h01};
    run_packet("raw_01", 2'b10, 1'b0, 4, 1'b0, 2'b00, 8'h00);
    check_rdy_count("raw_01", 1);
  endtask

  task automatic test_random();
    logic [1:0] mode;
    int         n, sel;
    glitch_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      mode = ($urandom_range(2) == 0) ? 2'b10 : 2'b00;
      n    = $urandom_range(3, 1);
      pkt_q.delete();
      for (int b = 0; b < n; b++) begin
        sel = $urandom_range(3);
        pkt_q.push_back(sel == 0 ? 8'hFF : (sel == 1 ? 8'h7E : 8'($urandom)));
      end
      run_packet("random", mode, 1'b0, $urandom_range(6, 1), 1'b0, 2'b00, 8'h00);
      check_rdy_count("random", (mode == 2'b10) ? n : n + 1);
    end
    glitch_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.utmi_txvalid_i  = 1'b0;
    bus.utmi_data_out_i = 8'h00;
    bus.utmi_op_mode_i  = 2'b00;
    test_reset();
    test_single_byte();
    test_stuff_ff();
    test_back_to_back();
    test_packet_chain();
    test_reset_mid_packet();
    test_nondriving();
    test_raw_single();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usbh_utmi_tx_phy.md
USBH_UTMI_TX_PHY -- requirements
Module: usbh_utmi_tx_phy

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk_i cycles per full-speed bit (48 MHz / 12 Mbps).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  48 MHz clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 utmi_data_out_i  input  8  transmit byte from controller, sent LSB first.
REQ-006 utmi_txvalid_i  input  1  controller has a byte; high for the whole packet.
REQ-007 utmi_op_mode_i  input  2  00 normal, 01/11 non-driving, 10 raw (no SYNC/EOP/NRZI/stuffing).
REQ-008 utmi_txready_o  output  1  one-cycle pulse; the byte on utmi_data_out_i is consumed that cycle.
REQ-009 usb_dp_o  output  1  D+ drive value.
REQ-010 usb_dn_o  output  1  D- drive value.
REQ-011 usb_tx_oen_o  output  1  active-low output enable; 0 = driving the bus.

Function
REQ-012 States SHALL be IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-013 IDLE: usb_tx_oen_o=1, dp/dn=J (1/0), txready=0.
REQ-014 In IDLE with txvalid=1 and op_mode=00 at edge n, SHALL enter SYNC with oen=0 and the first bit driven from edge n+1.
REQ-015 op_mode SHALL be sampled only on leaving IDLE and held for the packet; op_mode 01/11 SHALL keep the block in IDLE.
REQ-016 Bit timer SHALL count 0..CLKS_PER_BIT-1; every bit, stuffed bits included, is held exactly CLKS_PER_BIT cycles.
REQ-017 SYNC SHALL send 8'h80 LSB first; NRZI from J gives K J K J K J K K.
REQ-018 NRZI: a 0 bit SHALL toggle J/K; a 1 bit SHALL hold the line.
REQ-019 Ones counter SHALL clear at SYNC start, increment on each 1 (SYNC bits included) and clear on each 0.
REQ-020 On reaching 6, the next bit SHALL be a stuffed 0 and the counter SHALL clear.
REQ-021 txready SHALL pulse one cycle in the final cycle of the last SYNC bit and of each data byte's 8th bit.
REQ-022 If a stuff bit follows the 8th bit, the txready pulse SHALL move to the final cycle of the stuff bit.
REQ-023 At a txready pulse, txvalid=1 SHALL load the byte and stay in or enter DATA.
REQ-024 At a txready pulse, txvalid=0 SHALL enter EOP_SE0 and ignore utmi_data_out_i.
REQ-025 txvalid deassertion at any other time SHALL have no effect until the next txready point.
REQ-026 EOP_SE0 SHALL drive dp=dn=0 for 2 bit times, then EOP_J SHALL drive J for 1 bit time.
REQ-027 After EOP_J the block SHALL return to IDLE with oen=1.
REQ-028 A new packet SHALL NOT start in the same cycle IDLE is re-entered.
REQ-029 Raw mode (10) SHALL drive dp=bit, dn=~bit per data bit with no SYNC, no stuffing and no NRZI; the same txready rule applies.
REQ-030 In raw mode, txvalid=0 at a txready point SHALL return the block to IDLE, J on the line, oen=1, with no EOP.
REQ-031 When no packet is active, dp/dn SHALL never be SE0.

Reset
REQ-032 rst_i=1 at any edge, mid-packet included, SHALL force IDLE, oen=1, dp=1, dn=0, txready=0, and clear the timer, ones counter and shift register at the next edge.
REQ-033 No partial EOP SHALL be emitted after reset.

Structure
REQ-034 Package usbh_phy_pkg SHALL hold the state enum, line constants J/K/SE0, SYNC_BYTE=8'h80, STUFF_LIMIT=6 and op_mode constants.
REQ-035 One sub-module, usbh_tx_bitstuff_nrzi, SHALL implement the ones counter, stuff-request output and NRZI line register; the FSM, timer and shift register stay in the top.

Verification
REQ-036 Single byte 8'hA5, mode 00 -> line K J K J K J K K, then the NRZI of 10100101 LSB first, SE0 8 clks, J 4 clks, oen high; txready pulses exactly twice (byte load, then EOP decision).
REQ-037 Byte 8'hFF after SYNC -> stuff after the 5th data bit: K x5, J (stuff), J x3; 9 bits = 36 clks, txready in the last cycle of the stuff bit.
REQ-038 Bytes 8'h3F, 8'h00 back-to-back -> no idle gap between bytes; stuff inserted after 3F's bit 5; 8 toggles for 00.
REQ-039 rst_i asserted during the 3rd data bit -> next edge oen=1, dp/dn=1/0, txready=0; a fresh packet after release starts with a clean SYNC.
REQ-040 op_mode 01 with txvalid=1 for 100 clks -> oen stays 1, txready never pulses; op_mode 10 with byte 8'h01 -> dp 1,0,0,0,0,0,0,0 at 4 clks each, then IDLE J with no SE0.
